// File: rtl/ansi_diff_renderer.sv
// Diff-based VT100 renderer: scans master VRAM against a shadow copy and streams
// cursor-position, SGR and character bytes for every changed cell.
module ansi_diff_renderer #(
    parameter int COLS     = 64,
    parameter int ROWS     = 32,
    parameter int ADDR_W   = 11,
    parameter int OFFSET_X = 1,
    parameter int OFFSET_Y = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    output logic              VRAM_ENABLE,
    output logic [ADDR_W-1:0] VRAM_ADDR,
    input  logic [15:0]       VRAM_DATA_R,
    output logic              VRAM_LOCK,
    output logic              SIG_READY,
    input  logic              SIG_DRAW,
    input  logic              SIG_FULL,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY
);

    localparam int COL_W = $clog2(COLS);
    localparam int DEPTH = COLS * ROWS;

    localparam logic [7:0] ESC  = 8'h1b;
    localparam logic [7:0] LBR  = 8'h5b;
    localparam logic [7:0] SEMI = 8'h3b;

    // Hide cursor, then (full frame only) reset attributes to white-on-black and clear.
    localparam logic [159:0] PRE_SEQ = {
        8'h1b, 8'h5b, 8'h3f, 8'h32, 8'h35, 8'h6c,
        8'h1b, 8'h5b, 8'h30, 8'h3b, 8'h33, 8'h37, 8'h3b, 8'h34, 8'h30, 8'h6d,
        8'h1b, 8'h5b, 8'h32, 8'h4a
    };

    typedef enum logic [3:0] {
        S_IDLE, S_LOCK, S_PRE, S_RD, S_CMP, S_POS, S_SGR, S_CHR, S_NXT, S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   trk_q;
    logic [4:0]          idx_q;
    logic [15:0]         cell_q;
    logic [15:0]         shd_rd_q;
    logic [7:0]          attr_q;
    logic [7:0]          tx_dat_q;
    logic                tx_vld_q;
    logic                ready_q;
    logic                lock_q;
    logic                en_q;
    logic                full_pend_q;
    logic                attr_vld_q;
    logic                pos_vld_q;

    logic [15:0]         shd_mem [DEPTH];

    logic [7:0]          seq [20];
    logic [4:0]          seq_len;
    logic                can_load;
    logic                last_byte;
    logic                pos_skip;
    logic                sgr_skip;
    logic                cell_diff;
    logic                emit_en;
    logic                emit_done;

    function automatic logic [7:0] dig(input int v);
        return 8'(48 + v % 10);
    endfunction

    // {digit count, up to three ASCII digits left-aligned}, no leading zeros
    function automatic logic [25:0] dec3(input int v);
        if (v >= 100) return {2'd3, dig(v / 100), dig(v / 10), dig(v)};
        if (v >= 10)  return {2'd2, dig(v / 10), dig(v), 8'h00};
        return {2'd1, dig(v), 16'h0000};
    endfunction

    always_comb begin : seq_build
        logic [4:0]  n;
        logic [25:0] dy;
        logic [25:0] dx;
        for (int k = 0; k < 20; k++) seq[k] = 8'h00;
        seq_len = 5'd1;
        n  = 5'd0;
        dy = dec3(OFFSET_Y + int'(addr_q >> COL_W));
        dx = dec3(OFFSET_X + int'(addr_q[COL_W-1:0]));
        case (state_q)
            S_PRE: begin
                for (int k = 0; k < 20; k++) seq[k] = PRE_SEQ[159-8*k -: 8];
                seq_len = full_pend_q ? 5'd20 : 5'd6;
            end
            S_POS: begin
                seq[0] = ESC;
                seq[1] = LBR;
                n = 5'd2;
                for (int k = 0; k < 3; k++) begin
                    if (k < int'(dy[25:24])) begin
                        seq[n] = dy[23-8*k -: 8];
                        n = n + 5'd1;
                    end
                end
                seq[n] = SEMI;
                n = n + 5'd1;
                for (int k = 0; k < 3; k++) begin
                    if (k < int'(dx[25:24])) begin
                        seq[n] = dx[23-8*k -: 8];
                        n = n + 5'd1;
                    end
                end
                seq[n] = 8'h48;
                seq_len = n + 5'd1;
            end
            S_SGR: begin
                seq[0] = ESC;
                seq[1] = LBR;
                seq[2] = 8'h30;
                seq[3] = SEMI;
                n = 5'd4;
                if (cell_q[15]) begin
                    seq[n]        = 8'h31;
                    seq[n + 5'd1] = SEMI;
                    n = n + 5'd2;
                end
                if (cell_q[14]) begin
                    seq[n]        = 8'h34;
                    seq[n + 5'd1] = SEMI;
                    n = n + 5'd2;
                end
                seq[n]        = 8'h33;
                seq[n + 5'd1] = 8'h30 + {5'd0, cell_q[13:11]};
                seq[n + 5'd2] = SEMI;
                seq[n + 5'd3] = 8'h34;
                seq[n + 5'd4] = 8'h30 + {5'd0, cell_q[10:8]};
                seq[n + 5'd5] = 8'h6d;
                seq_len = n + 5'd6;
            end
            S_CHR: seq[0] = (cell_q[7:0] == 8'h00) ? 8'h20 : cell_q[7:0];
            default: ;
        endcase
    end

    assign can_load  = !tx_vld_q || TX_READY;
    assign last_byte = (idx_q == seq_len - 5'd1);
    assign pos_skip  = pos_vld_q && (trk_q == addr_q);
    assign sgr_skip  = attr_vld_q && (attr_q == cell_q[15:8]);
    assign cell_diff = (VRAM_DATA_R != shd_rd_q);
    assign emit_en   = (state_q == S_PRE) || (state_q == S_CHR) ||
                       ((state_q == S_POS) && !pos_skip) ||
                       ((state_q == S_SGR) && !sgr_skip);
    assign emit_done = emit_en && can_load && last_byte;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            trk_q       <= '0;
            idx_q       <= 5'd0;
            cell_q      <= 16'h0000;
            attr_q      <= 8'h00;
            tx_dat_q    <= 8'h00;
            tx_vld_q    <= 1'b0;
            ready_q     <= 1'b0;
            lock_q      <= 1'b0;
            en_q        <= 1'b0;
            full_pend_q <= 1'b1;
            attr_vld_q  <= 1'b0;
            pos_vld_q   <= 1'b0;
        end else begin
            en_q <= 1'b0;
            if (tx_vld_q && TX_READY) tx_vld_q <= 1'b0;
            // A new byte is loaded back-to-back with the one being accepted.
            if (emit_en && can_load) begin
                tx_dat_q <= seq[idx_q];
                tx_vld_q <= 1'b1;
                idx_q    <= last_byte ? 5'd0 : idx_q + 5'd1;
            end
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (ready_q && SIG_DRAW) begin
                        ready_q <= 1'b0;
                        lock_q  <= 1'b1;
                        if (SIG_FULL) full_pend_q <= 1'b1;
                        state_q <= S_LOCK;
                    end
                end
                S_LOCK: begin
                    pos_vld_q <= 1'b0;
                    idx_q     <= 5'd0;
                    state_q   <= S_PRE;
                end
                S_PRE: begin
                    if (emit_done) begin
                        if (full_pend_q) begin
                            attr_q     <= 8'h38;
                            attr_vld_q <= 1'b1;
                        end
                        addr_q  <= '0;
                        en_q    <= 1'b1;
                        state_q <= S_RD;
                    end
                end
                S_RD: state_q <= S_CMP;
                S_CMP: begin
                    cell_q <= VRAM_DATA_R;
                    if (!full_pend_q && !cell_diff)
                        state_q <= S_NXT;
                    else if (full_pend_q && VRAM_DATA_R == 16'h0000)
                        state_q <= S_NXT;
                    else
                        state_q <= S_POS;
                end
                S_POS: begin
                    if (pos_skip || emit_done) state_q <= S_SGR;
                end
                S_SGR: begin
                    if (sgr_skip) begin
                        state_q <= S_CHR;
                    end else if (emit_done) begin
                        attr_q     <= cell_q[15:8];
                        attr_vld_q <= 1'b1;
                        state_q    <= S_CHR;
                    end
                end
                S_CHR: begin
                    if (emit_done) begin
                        trk_q     <= addr_q + 1'b1;
                        pos_vld_q <= (addr_q[COL_W-1:0] != COL_W'(COLS - 1));
                        state_q   <= S_NXT;
                    end
                end
                S_NXT: begin
                    if (addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        en_q    <= 1'b1;
                        state_q <= S_RD;
                    end
                end
                S_DONE: begin
                    lock_q      <= 1'b0;
                    full_pend_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Shadow is written in CMP so a full frame leaves it an exact copy of VRAM.
    always_ff @(posedge CLK) begin
        if (RESET_N && state_q == S_CMP && (full_pend_q || cell_diff))
            shd_mem[addr_q] <= VRAM_DATA_R;
        if (state_q == S_RD)
            shd_rd_q <= shd_mem[addr_q];
    end

    assign VRAM_ENABLE = en_q;
    assign VRAM_ADDR   = addr_q;
    assign VRAM_LOCK   = lock_q;
    assign SIG_READY   = ready_q;
    assign TX_DATA     = tx_dat_q;
    assign TX_VALID    = tx_vld_q;

endmodule
